// File: rtl/bit_serial_adder_if.sv
// Valid/ready operand and result bus for bit_serial_adder.
// The Overflow signal exists only when BIT_SERIAL_ADDER_OVERFLOW_EN is defined.
interface bit_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] InputA;
  logic [WIDTH-1:0] InputB;
  logic             InputCarry;
  logic             InputSubtract;
  logic             InputValid;
  logic             InputReady;
  logic [WIDTH-1:0] Output;
  logic             OutputCarry;
  logic             OutputValid;
  logic             OutputReady;
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
  logic             Overflow;
`endif

  modport master (
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
    input  Overflow,
`endif
    output InputA, InputB, InputCarry, InputSubtract, InputValid, OutputReady,
    input  InputReady, Output, OutputCarry, OutputValid
  );

  modport slave (
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
    output Overflow,
`endif
    input  InputA, InputB, InputCarry, InputSubtract, InputValid, OutputReady,
    output InputReady, Output, OutputCarry, OutputValid
  );
endinterface

// File: rtl/bit_serial_adder.sv
// Bit-serial adder/subtractor: DIGIT_WIDTH bits per clock through one registered carry.
// Define BIT_SERIAL_ADDER_OVERFLOW_EN to add the registered signed-overflow output.
module bit_serial_adder #(
  parameter int WIDTH       = 8,
  parameter int DIGIT_WIDTH = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  bit_serial_adder_if.slave bus
);
  localparam int STEPS = WIDTH / DIGIT_WIDTH;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [DIGIT_WIDTH:0] digit_sum;
  logic               accept;
  logic               last_step;
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
  logic               ovf_q, ovf_d;
`endif

  assign accept    = bus.InputValid && in_ready_q;
  assign last_step = (cnt_q == CNT_W'(STEPS - 1));
  assign digit_sum = {1'b0, a_q[DIGIT_WIDTH-1:0]}
                   + {1'b0, b_q[DIGIT_WIDTH-1:0]}
                   + {{DIGIT_WIDTH{1'b0}}, carry_q};

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d      = bus.InputA;
          b_d      = bus.InputSubtract ? ~bus.InputB : bus.InputB;
          carry_d  = bus.InputCarry ^ bus.InputSubtract;
          cnt_d    = '0;
          result_d = '0;
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
          ovf_d    = 1'b0;
`endif
          state_d  = RUN;
        end
      end
      RUN: begin
        // New digit enters at the top; after STEPS shifts the LSB digit sits at bit 0.
        result_d = (result_q >> DIGIT_WIDTH)
                 | (WIDTH'(digit_sum[DIGIT_WIDTH-1:0]) << (WIDTH - DIGIT_WIDTH));
        carry_d  = digit_sum[DIGIT_WIDTH];
        a_d      = a_q >> DIGIT_WIDTH;
        b_d      = b_q >> DIGIT_WIDTH;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_step) begin
          state_d = DONE;
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
          // Carry into the MSB recovered from the MSB sum bit: a ^ b ^ s.
          ovf_d   = (a_q[DIGIT_WIDTH-1] ^ b_q[DIGIT_WIDTH-1] ^ digit_sum[DIGIT_WIDTH-1])
                  ^ digit_sum[DIGIT_WIDTH];
`endif
        end
      end
      DONE: begin
        if (bus.OutputReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (Reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.InputReady  = in_ready_q;
  assign bus.OutputValid = out_valid_q;
  assign bus.Output      = result_q;
  assign bus.OutputCarry = carry_q;
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
  assign bus.Overflow    = ovf_q;
`endif
endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder: an 8-bit/1-bit-digit and a 16-bit/4-bit-digit instance.
// Overflow expectations are compared only when BIT_SERIAL_ADDER_OVERFLOW_EN is defined.
module tb_bit_serial_adder;
  typedef struct {
    logic [15:0] res;
    logic        c;
    logic        o;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp8[$];
  exp_t exp16[$];
  int   acc8[$];
  int   acc16[$];
  bit   seen8 = 1'b0;
  bit   seen16 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bit_serial_adder_if #(.WIDTH(8))  b8();
  bit_serial_adder_if #(.WIDTH(16)) b16();

  bit_serial_adder #(.WIDTH(8),  .DIGIT_WIDTH(1)) u8  (.Clock(clk), .Reset(rst), .bus(b8));
  bit_serial_adder #(.WIDTH(16), .DIGIT_WIDTH(4)) u16 (.Clock(clk), .Reset(rst), .bus(b16));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency on the rising edge of OutputValid, data on each handshake.
  always @(negedge clk) begin
    if (rst) begin
      acc8.delete();
      acc16.delete();
      seen8  = 1'b0;
      seen16 = 1'b0;
    end else begin
      if (b8.InputValid && b8.InputReady) acc8.push_back(cyc + 1);
      if (b16.InputValid && b16.InputReady) acc16.push_back(cyc + 1);
      if (b8.OutputValid && !seen8) begin
        seen8 = 1'b1;
        if (acc8.size() == 0) check("lat8_no_accept", 0, 1);
        else check("lat8", cyc - acc8.pop_front(), 8);
      end
      if (b16.OutputValid && !seen16) begin
        seen16 = 1'b1;
        if (acc16.size() == 0) check("lat16_no_accept", 0, 1);
        else check("lat16", cyc - acc16.pop_front(), 4);
      end
      if (b8.OutputValid && b8.OutputReady) begin
        exp_t e;
        seen8 = 1'b0;
        if (exp8.size() == 0) check("out8_unexpected", 1, 0);
        else begin
          e = exp8.pop_front();
          check("out8_result", b8.Output, e.res[7:0]);
          check("out8_carry", b8.OutputCarry, e.c);
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
          check("out8_overflow", b8.Overflow, e.o);
`endif
        end
      end
      if (b16.OutputValid && b16.OutputReady) begin
        exp_t e;
        seen16 = 1'b0;
        if (exp16.size() == 0) check("out16_unexpected", 1, 0);
        else begin
          e = exp16.pop_front();
          check("out16_result", b16.Output, e.res);
          check("out16_carry", b16.OutputCarry, e.c);
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
          check("out16_overflow", b16.Overflow, e.o);
`endif
        end
      end
    end
  end

  // All stimulus tasks are entered and left at 1 time unit after a rising edge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub, input logic [7:0] er, input logic ec,
                        input logic eo, input bit expect_out);
    int n = 0;
    while (!b8.InputReady && n < 100) begin @(posedge clk); #1; n++; end
    check("ready8_wait", b8.InputReady, 1);
    if (expect_out) exp8.push_back('{res: {8'h00, er}, c: ec, o: eo});
    b8.InputA = a; b8.InputB = b; b8.InputCarry = cin; b8.InputSubtract = sub;
    b8.InputValid = 1'b1;
    @(posedge clk); #1;
    b8.InputValid = 1'b0;
    b8.InputA = ~a; b8.InputB = ~b; b8.InputCarry = ~cin; b8.InputSubtract = ~sub;
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, input logic [15:0] er, input logic ec,
                         input logic eo);
    int n = 0;
    while (!b16.InputReady && n < 100) begin @(posedge clk); #1; n++; end
    check("ready16_wait", b16.InputReady, 1);
    exp16.push_back('{res: er, c: ec, o: eo});
    b16.InputA = a; b16.InputB = b; b16.InputCarry = cin; b16.InputSubtract = sub;
    b16.InputValid = 1'b1;
    @(posedge clk); #1;
    b16.InputValid = 1'b0;
    b16.InputA = ~a; b16.InputB = ~b; b16.InputCarry = ~cin; b16.InputSubtract = ~sub;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp8.size() != 0 || exp16.size() != 0) && n < 300) begin @(posedge clk); #1; n++; end
    check("drain", exp8.size() + exp16.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    b8.InputA = '0;  b8.InputB = '0;  b8.InputCarry = 1'b0;  b8.InputSubtract = 1'b0;
    b8.InputValid = 1'b0;  b8.OutputReady = 1'b1;
    b16.InputA = '0; b16.InputB = '0; b16.InputCarry = 1'b0; b16.InputSubtract = 1'b0;
    b16.InputValid = 1'b0; b16.OutputReady = 1'b1;

    // Reset state
    @(posedge clk); #1;
    check("rst_in_ready8", b8.InputReady, 0);
    check("rst_out_valid8", b8.OutputValid, 0);
    check("rst_output8", b8.Output, 8'h00);
    check("rst_carry8", b8.OutputCarry, 0);
    check("rst_in_ready16", b16.InputReady, 0);
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
    check("rst_overflow8", b8.Overflow, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready8", b8.InputReady, 1);

    // Directed add/subtract vectors: a, b, cin, sub -> result, carry, overflow
    issue8(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b1);
    issue8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    issue8(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b1);
    issue8(8'h20, 8'h10, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 1'b1);
    issue8(8'h0F, 8'h01, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    issue8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
    issue8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1);
    issue8(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
    wait_drain();

    // Backpressure: result held in DONE, new operands ignored until IDLE
    b8.OutputReady = 1'b0;
    issue8(8'h33, 8'h44, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 1'b1);
    begin
      int n = 0;
      while (!b8.OutputValid && n < 50) begin @(posedge clk); #1; n++; end
    end
    check("bp_valid_seen", b8.OutputValid, 1);
    b8.InputA = 8'h01; b8.InputB = 8'h02; b8.InputCarry = 1'b0; b8.InputSubtract = 1'b0;
    b8.InputValid = 1'b1;
    exp8.push_back('{res: 16'h0003, c: 1'b0, o: 1'b0});
    for (int i = 0; i < 5; i++) begin
      check("bp_output", b8.Output, 8'h77);
      check("bp_out_valid", b8.OutputValid, 1);
      check("bp_in_ready", b8.InputReady, 0);
      @(posedge clk); #1;
    end
    b8.OutputReady = 1'b1;
    @(posedge clk); #1;
    check("bp_valid_drop", b8.OutputValid, 0);
    check("bp_ready_idle", b8.InputReady, 1);
    @(posedge clk); #1;
    check("bp_accepted", b8.InputReady, 0);
    b8.InputValid = 1'b0;
    b8.InputA = 8'hFF; b8.InputB = 8'hFF;
    wait_drain();

    // Reset at RUN step 3 aborts the operation
    issue8(8'h55, 8'h0F, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_out_valid", b8.OutputValid, 0);
    check("abort_output", b8.Output, 8'h00);
    check("abort_carry", b8.OutputCarry, 0);
    check("abort_in_ready", b8.InputReady, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_idle", b8.InputReady, 1);
    issue8(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
    wait_drain();

    // 16-bit, 4-bit digits
    issue16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    issue16(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    issue16(16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
